// File: rtl/stage23_transfer_if.sv
// Stage-2 to stage-3 transfer bus: pipeline control, stage-2 results, registered stage-3 operands
// and forwarding hints.
interface stage23_transfer_if;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_jump;
  logic [31:0] in_pc;
  logic [31:0] in_alu_out;
  logic [31:0] in_rs2d;
  logic [31:0] in_inst;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [31:0] rs2d;
  logic [31:0] inst;
  logic        valid;
  logic        jump;
  logic        fwd_rs1;
  logic        fwd_rs2;
  logic [31:0] instret;

  modport master (
    output stall, flush, in_valid, in_jump, in_pc, in_alu_out, in_rs2d, in_inst,
    input  pc, alu_out, rs2d, inst, valid, jump, fwd_rs1, fwd_rs2, instret
  );

  modport slave (
    input  stall, flush, in_valid, in_jump, in_pc, in_alu_out, in_rs2d, in_inst,
    output pc, alu_out, rs2d, inst, valid, jump, fwd_rs1, fwd_rs2, instret
  );
endinterface

// File: rtl/stage23_transfer.sv
// Stage-2 -> stage-3 pipeline register with stall hold, flush/bubble insertion and rd forwarding.
// Optional retired-instruction counter enabled by macro STAGE23_INSTRET_EN.
module stage23_transfer #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input logic              clk,
    input logic              reset,
    stage23_transfer_if.slave bus
);

    logic [31:0] pc_q;
    logic [31:0] alu_out_q;
    logic [31:0] rs2d_q;
    logic [31:0] inst_q;
    logic        valid_q;
    logic        jump_q;
    logic        flush_pending;
    logic        kill;

    assign kill = bus.flush | flush_pending;

    function automatic logic writes_rd(input logic [6:0] opcode);
        case (opcode)
            7'b0110111,           // LUI
            7'b0010111,           // AUIPC
            7'b1101111,           // JAL
            7'b1100111,           // JALR
            7'b0000011,           // LOAD
            7'b0010011,           // ARI_I
            7'b0110011,           // ARI_R
            7'b1110011: writes_rd = 1'b1;  // CSR
            default:    writes_rd = 1'b0;
        endcase
    endfunction

    // A flush seen while stalled is remembered and turned into a bubble on the first free edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= PC_RESET;
            alu_out_q     <= '0;
            rs2d_q        <= '0;
            inst_q        <= NOP_INST;
            valid_q       <= 1'b0;
            jump_q        <= 1'b0;
            flush_pending <= 1'b0;
        end else if (bus.stall) begin
            if (bus.flush) flush_pending <= 1'b1;
        end else begin
            flush_pending <= 1'b0;
            if (kill) begin
                pc_q      <= PC_RESET;
                alu_out_q <= '0;
                rs2d_q    <= '0;
                inst_q    <= NOP_INST;
                valid_q   <= 1'b0;
                jump_q    <= 1'b0;
            end else begin
                pc_q      <= bus.in_pc;
                alu_out_q <= bus.in_alu_out;
                rs2d_q    <= bus.in_rs2d;
                inst_q    <= bus.in_inst;
                valid_q   <= bus.in_valid;
                jump_q    <= bus.in_jump;
            end
        end
    end

    logic rd_live;
    assign rd_live = bus.in_valid && valid_q && writes_rd(inst_q[6:0]) && (inst_q[11:7] != 5'd0);

    assign bus.fwd_rs1 = rd_live && (inst_q[11:7] == bus.in_inst[19:15]);
    assign bus.fwd_rs2 = rd_live && (inst_q[11:7] == bus.in_inst[24:20]);

    assign bus.pc      = pc_q;
    assign bus.alu_out = alu_out_q;
    assign bus.rs2d    = rs2d_q;
    assign bus.inst    = inst_q;
    assign bus.valid   = valid_q;
    assign bus.jump    = jump_q;

`ifdef STAGE23_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            instret_q <= '0;
        else if (!bus.stall && !kill && bus.in_valid)
            instret_q <= instret_q + 32'd1;
    end

    assign bus.instret = instret_q;
`else
    assign bus.instret = '0;
`endif

endmodule

// File: tb/tb_stage23_transfer.sv
// Directed self-checking bench for stage23_transfer: capture, stall, flush, forwarding, async reset.
module tb_stage23_transfer;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [31:0] exp_instret;

    stage23_transfer_if bus ();

    stage23_transfer #(
        .NOP_INST(32'h0000_0013),
        .PC_RESET(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i);
        bus.in_valid   = v;
        bus.in_pc      = p;
        bus.in_inst    = i;
        bus.in_alu_out = p + 32'h10;
        bus.in_rs2d    = p + 32'h20;
        bus.in_jump    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 32'h0000_0040, 32'h0010_8133);
        step();
        step();
        tests++; if (bus.inst !== 32'h0000_0013) begin fails++; $display("FAIL rst_inst got %h exp %h", bus.inst, 32'h13); end
        tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp %h", bus.pc, 32'h0); end
        tests++; if (bus.valid !== 1'b0 || bus.jump !== 1'b0) begin fails++; $display("FAIL rst_vj got %b%b exp 00", bus.valid, bus.jump); end
        tests++; if (bus.alu_out !== 32'h0 || bus.rs2d !== 32'h0) begin fails++; $display("FAIL rst_ops got %h %h exp 0 0", bus.alu_out, bus.rs2d); end
        tests++; if (bus.fwd_rs1 !== 1'b0 || bus.fwd_rs2 !== 1'b0) begin fails++; $display("FAIL rst_fwd got %b%b exp 00", bus.fwd_rs1, bus.fwd_rs2); end
        tests++; if (bus.instret !== 32'h0) begin fails++; $display("FAIL rst_instret got %h exp 0", bus.instret); end
    endtask

    task automatic test_capture();
        reset = 1'b1;
        drive(1'b1, 32'h0000_0100, 32'h0050_0093);
        bus.in_jump = 1'b1;
        step();
        exp_instret = exp_instret + 32'd1;
        tests++; if (bus.pc !== 32'h100) begin fails++; $display("FAIL cap_pc got %h exp %h", bus.pc, 32'h100); end
        tests++; if (bus.inst !== 32'h0050_0093) begin fails++; $display("FAIL cap_inst got %h exp %h", bus.inst, 32'h00500093); end
        tests++; if (bus.valid !== 1'b1 || bus.jump !== 1'b1) begin fails++; $display("FAIL cap_vj got %b%b exp 11", bus.valid, bus.jump); end
        tests++; if (bus.alu_out !== 32'h110 || bus.rs2d !== 32'h120) begin fails++; $display("FAIL cap_ops got %h %h exp 110 120", bus.alu_out, bus.rs2d); end
    endtask

    task automatic test_forwarding();
        // registered: addi x1,x0,5
        bus.in_inst = 32'h0010_8133; #1;
        tests++; if ({bus.fwd_rs1, bus.fwd_rs2} !== 2'b11) begin fails++; $display("FAIL fwd_both got %b%b exp 11", bus.fwd_rs1, bus.fwd_rs2); end
        bus.in_inst = 32'h0020_8133; #1;
        tests++; if ({bus.fwd_rs1, bus.fwd_rs2} !== 2'b10) begin fails++; $display("FAIL fwd_rs1_only got %b%b exp 10", bus.fwd_rs1, bus.fwd_rs2); end
        bus.in_inst = 32'h0011_0133; #1;
        tests++; if ({bus.fwd_rs1, bus.fwd_rs2} !== 2'b01) begin fails++; $display("FAIL fwd_rs2_only got %b%b exp 01", bus.fwd_rs1, bus.fwd_rs2); end
        bus.in_inst = 32'h0010_8133; bus.in_valid = 1'b0; #1;
        tests++; if ({bus.fwd_rs1, bus.fwd_rs2} !== 2'b00) begin fails++; $display("FAIL fwd_in_invalid got %b%b exp 00", bus.fwd_rs1, bus.fwd_rs2); end
        // store with bits[11:7]=1 must not forward
        drive(1'b1, 32'h0000_0104, 32'h0011_20A3);
        step();
        exp_instret = exp_instret + 32'd1;
        bus.in_inst = 32'h0010_8133; #1;
        tests++; if ({bus.fwd_rs1, bus.fwd_rs2} !== 2'b00) begin fails++; $display("FAIL fwd_store got %b%b exp 00", bus.fwd_rs1, bus.fwd_rs2); end
        // lui x0 writes rd but rd is x0
        drive(1'b1, 32'h0000_0108, 32'h0000_0037);
        step();
        exp_instret = exp_instret + 32'd1;
        bus.in_inst = 32'h0000_0133; #1;
        tests++; if ({bus.fwd_rs1, bus.fwd_rs2} !== 2'b00) begin fails++; $display("FAIL fwd_rd_x0 got %b%b exp 00", bus.fwd_rs1, bus.fwd_rs2); end
        // lui x2 forwards on rs2 only
        drive(1'b1, 32'h0000_010C, 32'h1234_5137);
        step();
        exp_instret = exp_instret + 32'd1;
        bus.in_inst = 32'h0020_8133; #1;
        tests++; if ({bus.fwd_rs1, bus.fwd_rs2} !== 2'b01) begin fails++; $display("FAIL fwd_lui got %b%b exp 01", bus.fwd_rs1, bus.fwd_rs2); end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h0000_0104, 32'h0050_0093);
        step();
        exp_instret = exp_instret + 32'd1;
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0000_0200 + 32'(k * 4), 32'h0000_0033);
            step();
            tests++; if (bus.pc !== 32'h104 || bus.inst !== 32'h0050_0093) begin fails++; $display("FAIL stall_hold%0d got %h %h exp 104 00500093", k, bus.pc, bus.inst); end
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_flush_stall();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 32'h0000_0300, 32'h0000_0033);
        step();
        tests++; if (bus.pc !== 32'h104 || bus.valid !== 1'b1) begin fails++; $display("FAIL flush_stall_hold got %h %b exp 104 1", bus.pc, bus.valid); end
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 32'h0000_0304, 32'h0050_0093);
        bus.in_jump = 1'b1;
        step();
        tests++; if (bus.inst !== 32'h13 || bus.valid !== 1'b0 || bus.jump !== 1'b0 || bus.pc !== 32'h0 || bus.alu_out !== 32'h0) begin
            fails++; $display("FAIL pend_bubble got inst=%h v=%b j=%b pc=%h alu=%h exp 00000013 0 0 0 0", bus.inst, bus.valid, bus.jump, bus.pc, bus.alu_out);
        end
        drive(1'b1, 32'h0000_0308, 32'h0050_0093);
        step();
        exp_instret = exp_instret + 32'd1;
        tests++; if (bus.pc !== 32'h308 || bus.valid !== 1'b1) begin fails++; $display("FAIL post_bubble got %h %b exp 308 1", bus.pc, bus.valid); end
        // direct flush drops the incoming instruction
        bus.flush = 1'b1;
        drive(1'b1, 32'h0000_030C, 32'h0050_0093);
        step();
        bus.flush = 1'b0;
        tests++; if (bus.inst !== 32'h13 || bus.valid !== 1'b0 || bus.pc !== 32'h0) begin fails++; $display("FAIL flush_bubble got %h %b %h exp 00000013 0 0", bus.inst, bus.valid, bus.pc); end
        // invalid input does not count
        drive(1'b0, 32'h0000_0310, 32'h0000_0033);
        step();
        tests++; if (bus.valid !== 1'b0 || bus.pc !== 32'h310) begin fails++; $display("FAIL invalid_cap got %b %h exp 0 310", bus.valid, bus.pc); end
    endtask

    task automatic test_instret();
`ifdef STAGE23_INSTRET_EN
        tests++; if (bus.instret !== exp_instret) begin fails++; $display("FAIL instret got %h exp %h", bus.instret, exp_instret); end
`else
        tests++; if (bus.instret !== 32'h0) begin fails++; $display("FAIL instret_off got %h exp 0", bus.instret); end
`endif
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h0000_0400, 32'h0050_0093);
        step();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        tests++; if (bus.valid !== 1'b0 || bus.inst !== 32'h13) begin fails++; $display("FAIL async_rst got %b %h exp 0 00000013", bus.valid, bus.inst); end
        tests++; if (bus.instret !== 32'h0) begin fails++; $display("FAIL async_rst_instret got %h exp 0", bus.instret); end
        step();
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b1, 32'h0000_0500, 32'h0000_00B3);
        step();
        tests++; if (bus.pc !== 32'h500 || bus.valid !== 1'b1 || bus.inst !== 32'h0000_00B3) begin
            fails++; $display("FAIL rst_release_cap got %h %b %h exp 500 1 000000b3", bus.pc, bus.valid, bus.inst);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_instret = '0;
        test_reset();
        test_capture();
        test_forwarding();
        test_stall();
        test_flush_stall();
        test_instret();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
